// File: rtl/bus_pkg.sv
// Shared system-bus types and grant helpers.
// Reused by the arbiter, the write-data mux and the read mux.
package bus_pkg;

    localparam int NUM_MST_MAX = 16;

    typedef logic [NUM_MST_MAX-1:0] grant_t;
    typedef logic [3:0]             mst_idx_t;

    localparam mst_idx_t DEF_MST = 4'd0;

    function automatic grant_t idx_to_onehot(input mst_idx_t idx);
        grant_t oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic mst_idx_t onehot_to_idx(input grant_t oh);
        mst_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_MST_MAX; i++) begin
            if (oh[i]) begin
                idx = mst_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search starting just above the last owner.
// The last owner itself is examined last, so a lone owner is re-found.
module rr_picker #(
    parameter int N = 16
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   last,
    output logic         found,
    output logic [3:0]   win
);

    int idx;

    always_comb begin
        found = 1'b0;
        win   = 4'd0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = 4'(idx);
            end
        end
    end

endmodule

// File: rtl/master_arbiter.sv
// Round-robin system-bus arbiter with bounded tenure and locked transfers.
// All state advances only on transfer boundaries (MsRDY=1).
module master_arbiter #(
    parameter int NUM_MST  = 16,
    parameter int DEF_MST  = int'(bus_pkg::DEF_MST),
    parameter int MAX_HOLD = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MsRDY,
    input  logic [NUM_MST-1:0] MREQ,
    input  logic [NUM_MST-1:0] MLOCK,
    output logic [NUM_MST-1:0] AmCMUX,
    output logic [3:0]         AmGNT,
    output logic               AmLOCKED
);

    import bus_pkg::*;

    localparam mst_idx_t DEF_IDX  = mst_idx_t'(DEF_MST);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [NUM_MST-1:0] cmux_q, cmux_d;
    mst_idx_t           gnt_q, gnt_d;
    logic               locked_q, locked_d;
    logic [7:0]         hold_q, hold_d;

    grant_t   req_ext, lock_ext, win_oh, def_oh;
    logic     found;
    mst_idx_t win;

    rr_picker #(.N(NUM_MST)) u_picker (
        .req   (MREQ),
        .last  (gnt_q),
        .found (found),
        .win   (win)
    );

    always_comb begin
        req_ext              = '0;
        lock_ext             = '0;
        req_ext[NUM_MST-1:0] = MREQ;
        lock_ext[NUM_MST-1:0] = MLOCK;
        win_oh               = idx_to_onehot(win);
        def_oh               = idx_to_onehot(DEF_IDX);
    end

    always_comb begin
        cmux_d   = cmux_q;
        gnt_d    = gnt_q;
        locked_d = locked_q;
        hold_d   = hold_q;
        if (MsRDY) begin
            if (req_ext[gnt_q] && lock_ext[gnt_q]) begin
                locked_d = 1'b1;
            end else if (req_ext[gnt_q] && hold_q < HOLD_LIM) begin
                hold_d   = hold_q + 8'd1;
                locked_d = 1'b0;
            end else if (found) begin
                cmux_d   = win_oh[NUM_MST-1:0];
                gnt_d    = win;
                hold_d   = 8'd0;
                locked_d = lock_ext[win];
            end else begin
                cmux_d   = def_oh[NUM_MST-1:0];
                gnt_d    = DEF_IDX;
                hold_d   = 8'd0;
                locked_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmux_q   <= def_oh[NUM_MST-1:0];
            gnt_q    <= DEF_IDX;
            locked_q <= 1'b0;
            hold_q   <= 8'd0;
        end else begin
            cmux_q   <= cmux_d;
            gnt_q    <= gnt_d;
            locked_q <= locked_d;
            hold_q   <= hold_d;
        end
    end

    assign AmCMUX   = cmux_q;
    assign AmGNT    = gnt_q;
    assign AmLOCKED = locked_q;

endmodule

// File: tb/tb_master_arbiter.sv
// Directed bench for master_arbiter with MAX_HOLD=4 and 16 masters.
module tb_master_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MsRDY;
    logic [15:0] MREQ;
    logic [15:0] MLOCK;
    logic [15:0] AmCMUX;
    logic [3:0]  AmGNT;
    logic        AmLOCKED;

    int checks   = 0;
    int failures = 0;

    master_arbiter #(
        .NUM_MST  (16),
        .DEF_MST  (0),
        .MAX_HOLD (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .MsRDY    (MsRDY),
        .MREQ     (MREQ),
        .MLOCK    (MLOCK),
        .AmCMUX   (AmCMUX),
        .AmGNT    (AmGNT),
        .AmLOCKED (AmLOCKED)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST   = 1'b1;
        MsRDY = 1'b0;
        MREQ  = '0;
        MLOCK = '0;
        #2;
        checks++;
        if (AmCMUX !== 16'h0001 || AmGNT !== 4'd0 || AmLOCKED !== 1'b0) begin
            failures++;
            $display("FAIL reset: cmux=%h gnt=%0d lk=%b want 0001/0/0",
                     AmCMUX, AmGNT, AmLOCKED);
        end
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_single();
        MsRDY = 1'b1;
        MREQ  = 16'h0020;
        step();
        checks++;
        if (AmCMUX !== 16'h0020 || AmGNT !== 4'd5) begin
            failures++;
            $display("FAIL single_grant: cmux=%h gnt=%0d want 0020/5",
                     AmCMUX, AmGNT);
        end
        MREQ = 16'h0000;
        step();
        checks++;
        if (AmCMUX !== 16'h0001 || AmGNT !== 4'd0) begin
            failures++;
            $display("FAIL single_idle: cmux=%h gnt=%0d want 0001/0",
                     AmCMUX, AmGNT);
        end
    endtask

    task automatic test_tenure();
        logic [3:0] exp_seq [9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        MsRDY = 1'b1;
        MREQ  = 16'h0006;
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (AmGNT !== exp_seq[i] || AmCMUX !== (16'h1 << exp_seq[i])) begin
                failures++;
                $display("FAIL tenure[%0d]: gnt=%0d cmux=%h want %0d",
                         i, AmGNT, AmCMUX, exp_seq[i]);
            end
        end
    endtask

    task automatic test_freeze();
        logic [3:0] exp_seq [3] = '{3, 3, 8};
        MsRDY = 1'b1;
        MREQ  = 16'h0008;
        step();
        MREQ = 16'h0108;
        step();
        checks++;
        if (AmGNT !== 4'd3) begin
            failures++;
            $display("FAIL freeze_setup: gnt=%0d want 3", AmGNT);
        end
        MsRDY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            MREQ  = (i % 2 == 0) ? 16'h0000 : 16'hFFF0;
            MLOCK = (i % 3 == 0) ? 16'hFFFF : 16'h0000;
            step();
            checks++;
            if (AmGNT !== 4'd3 || AmCMUX !== 16'h0008 || AmLOCKED !== 1'b0) begin
                failures++;
                $display("FAIL freeze[%0d]: gnt=%0d cmux=%h lk=%b want 3/0008/0",
                         i, AmGNT, AmCMUX, AmLOCKED);
            end
        end
        MREQ  = 16'h0108;
        MLOCK = 16'h0000;
        MsRDY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (AmGNT !== exp_seq[i]) begin
                failures++;
                $display("FAIL freeze_resume[%0d]: gnt=%0d want %0d",
                         i, AmGNT, exp_seq[i]);
            end
        end
    endtask

    task automatic test_lock();
        logic [3:0] exp_seq [4] = '{2, 2, 2, 3};
        MsRDY = 1'b1;
        MREQ  = 16'h0004;
        MLOCK = 16'h0004;
        step();
        checks++;
        if (AmGNT !== 4'd2 || AmLOCKED !== 1'b1) begin
            failures++;
            $display("FAIL lock_enter: gnt=%0d lk=%b want 2/1", AmGNT, AmLOCKED);
        end
        MREQ = 16'h0FFF;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (AmGNT !== 4'd2 || AmLOCKED !== 1'b1) begin
                failures++;
                $display("FAIL lock_hold[%0d]: gnt=%0d lk=%b want 2/1",
                         i, AmGNT, AmLOCKED);
            end
        end
        MLOCK = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (AmGNT !== exp_seq[i] || AmLOCKED !== 1'b0) begin
                failures++;
                $display("FAIL lock_release[%0d]: gnt=%0d lk=%b want %0d/0",
                         i, AmGNT, AmLOCKED, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wrap();
        MsRDY = 1'b1;
        MREQ  = 16'h8000;
        step();
        checks++;
        if (AmGNT !== 4'd15 || AmCMUX !== 16'h8000) begin
            failures++;
            $display("FAIL wrap_setup: gnt=%0d cmux=%h want 15/8000",
                     AmGNT, AmCMUX);
        end
        MREQ = 16'h8001;
        step();
        MREQ = 16'h0001;
        step();
        checks++;
        if (AmGNT !== 4'd0 || AmCMUX !== 16'h0001) begin
            failures++;
            $display("FAIL wrap: gnt=%0d cmux=%h want 0/0001", AmGNT, AmCMUX);
        end
    endtask

    task automatic test_reset_mid();
        MsRDY = 1'b1;
        MREQ  = 16'h0040;
        MLOCK = 16'h0040;
        step();
        checks++;
        if (AmGNT !== 4'd6 || AmLOCKED !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_setup: gnt=%0d lk=%b want 6/1",
                     AmGNT, AmLOCKED);
        end
        #1;
        RST = 1'b1;
        #1;
        checks++;
        if (AmCMUX !== 16'h0001 || AmGNT !== 4'd0 || AmLOCKED !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: cmux=%h gnt=%0d lk=%b want 0001/0/0",
                     AmCMUX, AmGNT, AmLOCKED);
        end
        step();
        RST   = 1'b0;
        MREQ  = 16'h0000;
        MLOCK = 16'h0000;
        step();
        checks++;
        if (AmCMUX !== 16'h0001 || AmGNT !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_after: cmux=%h gnt=%0d want 0001/0",
                     AmCMUX, AmGNT);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tenure();
        test_freeze();
        test_lock();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/master_arbiter.md
Name: master_arbiter

Overview:
- Round-robin bus arbiter for the 16-master system bus.
- Produces the one-hot address-phase grant AmCMUX consumed by the write-data mux. That mux registers the grant on MsRDY to steer master write data in the data phase.
- Grant changes only at transfer boundaries (MsRDY=1), with bounded tenure per master and locked-transfer support.

Parameters:
- NUM_MST, 16, number of masters; legal 2..16; must be 16 when paired with the write-data mux.
- DEF_MST, 0, default master index granted when nobody requests.
- MAX_HOLD, 4, max consecutive transfers one master keeps the bus while others request; legal 1..255.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset; asynchronous, active-high.
- MsRDY  in  1  selected slave ready; 1 = current transfer completes this cycle.
- MREQ  in  NUM_MST  bus request, bit i = master i.
- MLOCK  in  NUM_MST  locked-transfer request, bit i = master i; meaningful only with MREQ[i].
- AmCMUX  out  NUM_MST  registered one-hot grant, address phase.
- AmGNT  out  4  registered binary index of the granted master.
- AmLOCKED  out  1  registered; 1 = current owner holds the bus under lock.

Behaviour:
- Reset (async, RST=1): AmCMUX = one-hot(DEF_MST), AmGNT = DEF_MST, AmLOCKED = 0, hold_cnt = 0.
  - Reset asserted mid-tenure discards the owner immediately; no pending state survives.
- Freeze: any cycle with MsRDY=0 leaves all state unchanged (AmCMUX, AmGNT, AmLOCKED, hold_cnt), whatever MREQ/MLOCK do.
- Decision on each rising CLK with MsRDY=1; cur = AmGNT. Rules in priority order:
  - Lock: MREQ[cur] & MLOCK[cur] → keep cur; hold_cnt unchanged; AmLOCKED <= 1. MAX_HOLD is ignored while locked.
  - Hold: MREQ[cur] & hold_cnt < MAX_HOLD-1 → keep cur; hold_cnt <= hold_cnt+1; AmLOCKED <= 0.
  - Rotate: otherwise, search indices cur+1, cur+2, …, wrapping modulo NUM_MST, ending at cur itself. The first i with MREQ[i]=1 wins.
    - AmCMUX <= one-hot(i), AmGNT <= i, hold_cnt <= 0, AmLOCKED <= MLOCK[i].
    - If the only requester is cur, it is re-granted with hold_cnt reset to 0.
  - Idle: no MREQ bit set → grant DEF_MST, hold_cnt <= 0, AmLOCKED <= 0.
- Latency: a request sampled at edge N (MsRDY=1, bus rotatable) shows on AmCMUX/AmGNT after edge N; one-cycle registered latency.
- Invariants:
  - AmCMUX is exactly one-hot at all times, including after reset.
  - AmGNT always encodes AmCMUX.
- hold_cnt width is 8 bits; it never exceeds MAX_HOLD-1.
- Request dropped by the owner while MsRDY=0: no effect until the next MsRDY=1 edge, which then applies the Rotate/Idle rules.
- Lock released (MLOCK[cur]=0, MREQ[cur]=1) at a MsRDY=1 edge: the Hold rule applies using the current hold_cnt.
- Simultaneous requesters: the nearest index above cur (with wrap) wins. Index 15 wraps to 0.
- MREQ/MLOCK bits ≥ NUM_MST are absent; no X propagation into the grant.

Decomposition:
- Shared package bus_pkg:
  - NUM_MST_MAX = 16;
  - grant vector typedef (16-bit one-hot);
  - master index typedef (4-bit);
  - DEF_MST constant;
  - one-hot/index conversion functions. These are reused by the write-data mux and the read mux.
- Sub-module rr_picker, purely combinational:
  - inputs: request vector, last-owner index;
  - outputs: found flag, winner index.
- master_arbiter holds the registers, lock/hold control and the MsRDY gating.

Test Plan (MAX_HOLD=4 unless stated):
- Reset: RST=1 at any point, including mid-tenure → AmCMUX=16'h0001, AmGNT=0, AmLOCKED=0 immediately, without a clock edge.
- Single requester: MREQ=16'h0020, MsRDY=1 → after one edge AmCMUX=16'h0020, AmGNT=5. MREQ=0 at next edge → AmCMUX=16'h0001.
- Tenure limit: MREQ=16'h0006, MsRDY=1 continuously → AmGNT sequence 1,1,1,1,2,2,2,2,1…; hold_cnt resets on every switch.
- Freeze: owner 3 with MREQ=16'h0108 and MsRDY=0 for 10 cycles → AmGNT stays 3. First MsRDY=1 edge resumes counting from the frozen hold_cnt.
- Lock: owner 2 with MLOCK[2]=1 and MREQ=16'h0FFF for 20 MsRDY edges → AmGNT=2 and AmLOCKED=1 throughout. Dropping MLOCK[2] → rotation to 3 after the Hold rule expires.
- Wrap-around: owner 15, MREQ=16'h8001, MREQ[15] dropped at a MsRDY edge → AmGNT=0, AmCMUX=16'h0001.
